mult_simple: RTL and testbench



---
 rtl/mult_simple.sv | 90 +++++++++
 tb/tb_mult_simple.sv | 106 ++++++++++
 2 files changed

// File: rtl/mult_simple.sv
// rtl/mult_simple.sv - registered signed multiplier built from a partial-product adder tree.
// Optional input register stage enabled by MULT_SIMPLE_INPUT_REG_EN.
module mult_simple #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c
);

  localparam int P      = 2 * WIDTH;
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NP     = 1 << LEVELS;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

`ifdef MULT_SIMPLE_INPUT_REG_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  always_comb begin
    a_d = a;
    b_d = b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
`else
  assign op_a = a;
  assign op_b = b;
`endif

  logic [P-1:0] a_ext;
  logic [P-1:0] pp [NP];

  assign a_ext = {{WIDTH{op_a[WIDTH-1]}}, op_a};

  // The MSB of b carries negative weight, so its row is subtracted.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      pp[i] = '0;
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      pp[i] = op_b[i] ? (a_ext << i) : '0;
    end
    pp[WIDTH-1] = op_b[WIDTH-1] ? (P'(0) - (a_ext << (WIDTH - 1))) : '0;
  end

  genvar l, n;
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [P-1:0] s [NP >> l];
    if (l == 0) begin : g_leaf
      for (n = 0; n < NP; n++) begin : g_n
        assign s[n] = pp[n];
      end
    end else begin : g_sum
      for (n = 0; n < (NP >> l); n++) begin : g_n
        assign s[n] = g_lvl[l-1].s[2*n] + g_lvl[l-1].s[2*n+1];
      end
    end
  end

  logic [P-1:0] c_q, c_d;

  assign c_d = g_lvl[LEVELS].s[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_mult_simple.sv
// tb/tb_mult_simple.sv - randomized and directed checks of mult_simple against an arithmetic model.
module tb_mult_simple;

  localparam int W = 4;
  localparam int P = 2 * W;
`ifdef MULT_SIMPLE_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [P-1:0] c;

  int n_checks = 0;
  int n_fail   = 0;
  int pipe [LAT];

  mult_simple #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive operands, advance the model, compare the product.
  task automatic step(input int av, input int bv, input bit r, input string tag);
    @(negedge clk);
    a   = av[W-1:0];
    b   = bv[W-1:0];
    rst = r;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < LAT; i++) pipe[i] = 0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = av * bv;
    end
    #1;
    check(tag, int'($signed(c)), pipe[LAT-1]);
  endtask

  initial begin
    int lo, hi;
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    for (int i = 0; i < LAT; i++) pipe[i] = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;

    for (int i = 0; i < 4; i++) step(7, 7, 1'b1, "reset_hold");
    for (int i = 0; i < LAT; i++) step(7, 7, 1'b0, "reset_release");
    check("reset_release_49", int'($signed(c)), 49);

    for (int x = lo; x <= hi; x++)
      for (int y = lo; y <= hi; y++)
        step(x, y, 1'b0, "sweep");

    step(-8, -8, 1'b0, "ext_m8m8");
    step(-8,  7, 1'b0, "ext_m8p7");
    step( 7,  7, 1'b0, "ext_p7p7");
    step(-1, -1, 1'b0, "ext_m1m1");
    step( 0, -8, 1'b0, "ext_0m8");
    for (int i = 0; i < LAT; i++) step(0, 0, 1'b0, "ext_drain");

    step( 3,  5, 1'b0, "b2b_0");
    step(-2,  4, 1'b0, "b2b_1");
    step( 6, -1, 1'b0, "b2b_2");

    step(-3, 5, 1'b1, "mid_reset");
    for (int i = 0; i < LAT; i++) step(-3, 5, 1'b0, "mid_release");
    check("mid_release_m15", int'($signed(c)), -15);

    for (int i = 0; i < 2; i++) step(0, 0, 1'b1, "zero_reset");
    for (int i = 0; i < LAT; i++) step(0, 0, 1'b0, "zero_release");

    for (int i = 0; i < 300; i++) begin
      int x, y;
      bit r;
      x = int'($urandom_range(hi - lo, 0)) + lo;
      y = int'($urandom_range(hi - lo, 0)) + lo;
      r = ($urandom_range(19, 0) == 0);
      step(x, y, r, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
